sdr_bus_monitor: RTL and testbench

Target-side observer for the SDR SCL/SDA bus. It synchronizes the external SCL and SDA pins and produces single-cycle SCL edge strobes. It also detects START, Repeated START and STOP conditions, and tracks bus-free and bus-idle status. It sits between the pad inputs and the target SDR receive logic, and is the receive-end counterpart of the controller's SCL generator.

---
 rtl/sdr_bus_monitor.sv | 251 +++++++++++++++++++++++++
 tb/tb_sdr_bus_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_bus_monitor.sv
// sdr_bus_monitor: target-side SCL/SDA observer with edge strobes,
// START/RSTART/STOP detection and bus-free/idle tracking. Macro: SDR_BUS_MON_GLITCH_FILT_EN.
module sdr_bus_monitor #(
    parameter int BUS_FREE_CYCLES = 2,
    parameter int BUS_IDLE_CYCLES = 10000,
    parameter int FILT_CYCLES     = 3
) (
    input  logic       i_sdr_ctrl_clk,
    input  logic       i_sdr_ctrl_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl_pos_edge,
    output logic       o_scl_neg_edge,
    output logic       o_scl,
    output logic       o_sda_sample,
    output logic       o_start,
    output logic       o_rstart,
    output logic       o_stop,
    output logic [3:0] o_bit_cnt,
    output logic       o_bus_free,
    output logic       o_bus_idle
);

    typedef enum logic [1:0] {
        ST_WAIT_FREE,
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam logic [13:0] FREE_CNT = 14'(BUS_FREE_CYCLES);
    localparam logic [13:0] IDLE_CNT = 14'(BUS_IDLE_CYCLES);
    localparam logic [13:0] CNT_MAX  =
        (BUS_IDLE_CYCLES > BUS_FREE_CYCLES) ? IDLE_CNT : FREE_CNT;

    if (FILT_CYCLES < 2 || FILT_CYCLES > 7) begin : g_bad_filt
        $error("FILT_CYCLES must be in 2..7");
    end

    if (BUS_IDLE_CYCLES > 16383) begin : g_bad_idle
        $error("BUS_IDLE_CYCLES must not exceed 16383");
    end

    logic   r_scl_s1, r_scl_s2;
    logic   r_sda_s1, r_sda_s2;
    logic   w_scl_f, w_sda_f;
    logic   r_scl_d, r_sda_d;
    state_t r_state, w_state_nxt;
    logic [13:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_bit_cnt, w_bit_nxt;
    logic   w_scl_rise, w_scl_fall;
    logic   w_sda_rise, w_sda_fall;
    logic   w_scl_hi;
    logic   w_start_cond, w_stop_cond;
    logic   w_start, w_rstart, w_stop;
    logic   w_bus_idle_nxt;
    logic   r_pos, r_neg;
    logic   r_start, r_rstart, r_stop;
    logic   r_sda_sample;
    logic   r_bus_idle;

    // Two-flop synchronizers; pins idle high so flops reset to 1
    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= i_sda;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef SDR_BUS_MON_GLITCH_FILT_EN
    localparam logic [2:0] FILT_LAST = 3'(FILT_CYCLES - 1);

    logic [2:0] r_scl_fcnt, r_sda_fcnt;
    logic       r_scl_f, r_sda_f;

    // Glitch filter: follow the pin only after FILT_CYCLES differing samples
    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            r_scl_fcnt <= 3'd0;
            r_sda_fcnt <= 3'd0;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
        end else begin
            if (r_scl_s2 != r_scl_f) begin
                if (r_scl_fcnt == FILT_LAST) begin
                    r_scl_f    <= r_scl_s2;
                    r_scl_fcnt <= 3'd0;
                end else begin
                    r_scl_fcnt <= r_scl_fcnt + 3'd1;
                end
            end else begin
                r_scl_fcnt <= 3'd0;
            end
            if (r_sda_s2 != r_sda_f) begin
                if (r_sda_fcnt == FILT_LAST) begin
                    r_sda_f    <= r_sda_s2;
                    r_sda_fcnt <= 3'd0;
                end else begin
                    r_sda_fcnt <= r_sda_fcnt + 3'd1;
                end
            end else begin
                r_sda_fcnt <= 3'd0;
            end
        end
    end

    assign w_scl_f = r_scl_f;
    assign w_sda_f = r_sda_f;
`else
    assign w_scl_f = r_scl_s2;
    assign w_sda_f = r_sda_s2;
`endif

    // One-clock delayed copies of the filtered levels for edge detection
    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    assign w_scl_rise   = w_scl_f & ~r_scl_d;
    assign w_scl_fall   = ~w_scl_f & r_scl_d;
    assign w_sda_rise   = w_sda_f & ~r_sda_d;
    assign w_sda_fall   = ~w_sda_f & r_sda_d;
    // SCL stable high in both samples: an SCL edge blocks any condition
    assign w_scl_hi     = w_scl_f & r_scl_d;
    assign w_start_cond = w_sda_fall & w_scl_hi;
    assign w_stop_cond  = w_sda_rise & w_scl_hi;

    // Bus state register with free/idle counter and bit counter
    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            r_state    <= ST_WAIT_FREE;
            r_cnt      <= 14'd0;
            r_bit_cnt  <= 4'd0;
            r_bus_idle <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_bus_idle <= w_bus_idle_nxt;
        end
    end

    // Next state and condition strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rstart    = 1'b0;
        w_stop      = 1'b0;
        unique case (r_state)
            ST_WAIT_FREE: begin
                if (w_start_cond) begin
                    w_state_nxt = ST_BUSY;
                    w_start     = 1'b1;
                end else if (r_cnt >= FREE_CNT) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_start_cond) begin
                    w_state_nxt = ST_BUSY;
                    w_start     = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_start_cond) begin
                    w_rstart = 1'b1;
                end else if (w_stop_cond) begin
                    w_state_nxt = ST_WAIT_FREE;
                    w_stop      = 1'b1;
                end
            end
            default: w_state_nxt = ST_WAIT_FREE;
        endcase
    end

    // High-bus counter: saturates, clears on any low level or in BUSY
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ST_BUSY || w_state_nxt == ST_BUSY) begin
            w_cnt_nxt = 14'd0;
        end else if (w_scl_f && w_sda_f) begin
            if (r_cnt < CNT_MAX) begin
                w_cnt_nxt = r_cnt + 14'd1;
            end
        end else begin
            w_cnt_nxt = 14'd0;
        end
    end

    // Idle flag follows the counter reaching its limit while free
    always_comb begin
        w_bus_idle_nxt = (w_state_nxt == ST_IDLE) &&
                         (r_cnt >= IDLE_CNT) &&
                         w_scl_f && w_sda_f;
    end

    // Bit counter: 9 SCL rises per byte, cleared by (R)START
    always_comb begin
        w_bit_nxt = r_bit_cnt;
        if (w_start || w_rstart) begin
            w_bit_nxt = 4'd0;
        end else if (r_state == ST_BUSY && w_scl_rise) begin
            w_bit_nxt = (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
        end
    end

    // Registered strobes and SDA sample, aligned with o_scl
    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            r_pos        <= 1'b0;
            r_neg        <= 1'b0;
            r_start      <= 1'b0;
            r_rstart     <= 1'b0;
            r_stop       <= 1'b0;
            r_sda_sample <= 1'b0;
        end else begin
            r_pos    <= w_scl_rise;
            r_neg    <= w_scl_fall;
            r_start  <= w_start;
            r_rstart <= w_rstart;
            r_stop   <= w_stop;
            if (w_scl_rise) begin
                r_sda_sample <= w_sda_f;
            end
        end
    end

    assign o_scl_pos_edge = r_pos;
    assign o_scl_neg_edge = r_neg;
    assign o_scl          = r_scl_d;
    assign o_sda_sample   = r_sda_sample;
    assign o_start        = r_start;
    assign o_rstart       = r_rstart;
    assign o_stop         = r_stop;
    assign o_bit_cnt      = r_bit_cnt;
    assign o_bus_free     = (r_state == ST_IDLE);
    assign o_bus_idle     = r_bus_idle;

endmodule

// File: tb/tb_sdr_bus_monitor.sv
// tb_sdr_bus_monitor: directed bench for sdr_bus_monitor.
// Covers reset, free/idle timing, START/RSTART/STOP, bit count and reset mid-byte.
module tb_sdr_bus_monitor;

`ifdef SDR_BUS_MON_GLITCH_FILT_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif
    localparam int GAP = 8;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       sda;
    logic       o_scl_pos_edge;
    logic       o_scl_neg_edge;
    logic       o_scl;
    logic       o_sda_sample;
    logic       o_start;
    logic       o_rstart;
    logic       o_stop;
    logic [3:0] o_bit_cnt;
    logic       o_bus_free;
    logic       o_bus_idle;

    int n_total = 0;
    int n_bad   = 0;
    int n_pos   = 0;
    int n_neg   = 0;
    int n_start = 0;
    int n_stop  = 0;

    sdr_bus_monitor dut (
        .i_sdr_ctrl_clk   (clk),
        .i_sdr_ctrl_rst_n (rst_n),
        .i_scl            (scl),
        .i_sda            (sda),
        .o_scl_pos_edge   (o_scl_pos_edge),
        .o_scl_neg_edge   (o_scl_neg_edge),
        .o_scl            (o_scl),
        .o_sda_sample     (o_sda_sample),
        .o_start          (o_start),
        .o_rstart         (o_rstart),
        .o_stop           (o_stop),
        .o_bit_cnt        (o_bit_cnt),
        .o_bus_free       (o_bus_free),
        .o_bus_idle       (o_bus_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_scl_pos_edge) n_pos <= n_pos + 1;
        if (o_scl_neg_edge) n_neg <= n_neg + 1;
        if (o_start)        n_start <= n_start + 1;
        if (o_stop)         n_stop <= n_stop + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int exp_cnt);
        scl = 1'b0;
        step(GAP);
        sda = b;
        step(GAP);
        scl = 1'b1;
        step(LAT);
        check("bit_pos", o_scl_pos_edge, 1);
        check("bit_oscl", o_scl, 1);
        check("bit_sample", o_sda_sample, b);
        check("bit_cnt", o_bit_cnt, exp_cnt);
        step(GAP);
    endtask

    initial begin
        logic [7:0] byte_v;
        int p0, q0, s0, t0;
        byte_v = 8'hA5;
        rst_n = 1'b0;
        scl = 1'b1;
        sda = 1'b1;
        step(3);
        check("rst_scl", o_scl, 1);
        check("rst_free", o_bus_free, 0);
        check("rst_idle", o_bus_idle, 0);
        check("rst_start", o_start, 0);
        check("rst_cnt", o_bit_cnt, 0);
        check("rst_sample", o_sda_sample, 0);

        rst_n = 1'b1;
        step(2);
        check("free_early", o_bus_free, 0);
        step(1);
        check("free_rise", o_bus_free, 1);
        step(9997);
        check("idle_early", o_bus_idle, 0);
        step(1);
        check("idle_rise", o_bus_idle, 1);

        sda = 1'b0;
        step(LAT - 1);
        check("start_early", o_start, 0);
        check("free_pre", o_bus_free, 1);
        step(1);
        check("start", o_start, 1);
        check("start_free", o_bus_free, 0);
        check("start_idle", o_bus_idle, 0);
        check("start_cnt", o_bit_cnt, 0);
        step(1);
        check("start_width", o_start, 0);

        p0 = n_pos;
        q0 = n_neg;
        for (int i = 0; i < 9; i++) begin
            send_bit((i < 8) ? byte_v[7 - i] : 1'b0, (i + 1) % 9);
        end
        check("n_pos", n_pos - p0, 9);
        check("n_neg", n_neg - q0, 9);

        scl = 1'b0;
        step(GAP);
        sda = 1'b1;
        step(GAP);
        scl = 1'b1;
        step(GAP);
        check("pre_rs_cnt", o_bit_cnt, 1);
        s0 = n_start;
        sda = 1'b0;
        step(LAT - 1);
        check("rs_early", o_rstart, 0);
        step(1);
        check("rstart", o_rstart, 1);
        check("rs_cnt", o_bit_cnt, 0);
        step(1);
        check("rs_width", o_rstart, 0);
        check("rs_nostart", n_start - s0, 0);

        scl = 1'b0;
        step(GAP);
        scl = 1'b1;
        step(GAP);
        sda = 1'b1;
        step(LAT);
        check("stop", o_stop, 1);
        check("stop_free", o_bus_free, 0);
        step(2);
        check("stop_free2", o_bus_free, 0);
        step(1);
        check("stop_free3", o_bus_free, 1);
        step(GAP);

        s0 = n_start;
        t0 = n_stop;
        scl = 1'b0;
        sda = 1'b0;
        step(LAT);
        check("sim_neg", o_scl_neg_edge, 1);
        step(GAP);
        scl = 1'b1;
        sda = 1'b1;
        step(LAT);
        check("sim_pos", o_scl_pos_edge, 1);
        check("sim_sample", o_sda_sample, 1);
        step(GAP);
        check("sim_nostart", n_start - s0, 0);
        check("sim_nostop", n_stop - t0, 0);
        check("sim_free", o_bus_free, 1);

`ifdef SDR_BUS_MON_GLITCH_FILT_EN
        q0 = n_neg;
        scl = 1'b0;
        step(2);
        scl = 1'b1;
        step(GAP);
        check("glitch_neg", n_neg - q0, 0);
`endif

        sda = 1'b0;
        step(LAT + GAP);
        check("mid_start", n_start - s0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 2);
        send_bit(1'b1, 3);
        scl = 1'b0;
        step(GAP);
        check("mid_cnt", o_bit_cnt, 3);
        rst_n = 1'b0;
        scl = 1'b1;
        sda = 1'b1;
        step(1);
        check("mid_rst_cnt", o_bit_cnt, 0);
        check("mid_rst_scl", o_scl, 1);
        check("mid_rst_free", o_bus_free, 0);
        check("mid_rst_smp", o_sda_sample, 0);
        check("mid_rst_neg", o_scl_neg_edge, 0);
        rst_n = 1'b1;
        step(2);
        check("mid_free2", o_bus_free, 0);
        step(1);
        check("mid_free3", o_bus_free, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
